// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits IF and LSB requests into little-endian byte
// accesses on the single-port 8-bit RAM/IO bus, LSB taking priority over fetch.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_en,
  input  logic [31:0] if_a,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_en,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_a,
  input  logic [2:0]  lsb_l,
  input  logic [31:0] lsb_w,
  output logic        lsb_done,
  output logic [31:0] lsb_r
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    LOAD   = 2'd2,
    STORE  = 2'd3
  } state_t;

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [2:0] sel);
    case (sel)
      3'd0:    get_byte = word[7:0];
      3'd1:    get_byte = word[15:8];
      3'd2:    get_byte = word[23:16];
      3'd3:    get_byte = word[31:24];
      default: get_byte = 8'd0;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [2:0] sel,
                                           input logic [7:0] b);
    put_byte = word;
    case (sel)
      3'd0:    put_byte[7:0]   = b;
      3'd1:    put_byte[15:8]  = b;
      3'd2:    put_byte[23:16] = b;
      3'd3:    put_byte[31:24] = b;
      default: put_byte        = word;
    endcase
  endfunction

  state_t      state_r;
  logic [2:0]  idx_r;
  logic [2:0]  len_r;
  logic [31:0] base_r;
  logic [31:0] buf_r;
  logic [31:0] wdata_r;
  logic        wr_req_r;
  logic [31:0] mem_a_r;
  logic [7:0]  mem_dout_r;
  logic        if_done_r;
  logic [31:0] if_data_r;
  logic        lsb_done_r;
  logic [31:0] lsb_r_r;

  logic        io_stall_s;
  logic [2:0]  idx_next_s;
  logic [31:0] asm_s;

  // The byte in flight on mem_din belongs at position idx-1 of the assembled word.
  assign io_stall_s = (mem_a_r[17:16] == 2'b11) && io_buffer_full;
  assign idx_next_s = idx_r + 3'd1;
  assign asm_s      = put_byte(buf_r, idx_r - 3'd1, mem_din);

  assign mem_wr   = wr_req_r && rdy && !io_stall_s;
  assign mem_a    = mem_a_r;
  assign mem_dout = mem_dout_r;
  assign if_done  = if_done_r;
  assign if_data  = if_data_r;
  assign lsb_done = lsb_done_r;
  assign lsb_r    = lsb_r_r;

  // Request acceptance, byte issue/capture and registered bus/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= 3'd0;
      len_r      <= 3'd0;
      base_r     <= 32'd0;
      buf_r      <= 32'd0;
      wdata_r    <= 32'd0;
      wr_req_r   <= 1'b0;
      mem_a_r    <= 32'd0;
      mem_dout_r <= 8'd0;
      if_done_r  <= 1'b0;
      if_data_r  <= 32'd0;
      lsb_done_r <= 1'b0;
      lsb_r_r    <= 32'd0;
    end else if (rdy) begin
      if_done_r  <= 1'b0;
      lsb_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // A done still high means its requester has not yet dropped the enable.
          if (!rollback && !if_done_r && !lsb_done_r) begin
            if (lsb_en) begin
              base_r  <= lsb_a;
              len_r   <= lsb_l;
              wdata_r <= lsb_w;
              buf_r   <= 32'd0;
              idx_r   <= 3'd0;
              mem_a_r <= lsb_a;
              if (lsb_wr) begin
                state_r    <= STORE;
                mem_dout_r <= lsb_w[7:0];
                wr_req_r   <= 1'b1;
              end else begin
                state_r <= LOAD;
              end
            end else if (if_en) begin
              base_r  <= if_a;
              len_r   <= 3'd4;
              buf_r   <= 32'd0;
              idx_r   <= 3'd0;
              mem_a_r <= if_a;
              state_r <= IFETCH;
            end
          end
        end
        IFETCH, LOAD: begin
          if (state_r == IFETCH && rollback) begin
            state_r <= IDLE;
            idx_r   <= 3'd0;
          end else if (idx_r == len_r) begin
            state_r <= IDLE;
            idx_r   <= 3'd0;
            buf_r   <= asm_s;
            if (state_r == IFETCH) begin
              if_data_r <= asm_s;
              if_done_r <= 1'b1;
            end else begin
              lsb_r_r    <= asm_s;
              lsb_done_r <= 1'b1;
            end
          end else begin
            idx_r <= idx_next_s;
            if (idx_next_s < len_r) begin
              mem_a_r <= base_r + {29'd0, idx_next_s};
            end
            if (idx_r != 3'd0) begin
              buf_r <= asm_s;
            end
          end
        end
        STORE: begin
          if (!io_stall_s) begin
            if (idx_next_s == len_r) begin
              wr_req_r   <= 1'b0;
              lsb_done_r <= 1'b1;
              idx_r      <= 3'd0;
              state_r    <= IDLE;
            end else begin
              idx_r      <= idx_next_s;
              mem_a_r    <= base_r + {29'd0, idx_next_s};
              mem_dout_r <= get_byte(wdata_r, idx_next_s);
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          wr_req_r <= 1'b0;
          idx_r    <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model (frozen while rdy=0) plus a write log.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_en;
  logic [31:0] if_a;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_en;
  logic        lsb_wr;
  logic [31:0] lsb_a;
  logic [2:0]  lsb_l;
  logic [31:0] lsb_w;
  logic        lsb_done;
  logic [31:0] lsb_r;

  logic [7:0]  ram [0:4095];
  logic [31:0] wr_a_log [0:15];
  logic [7:0]  wr_d_log [0:15];
  int          wr_cnt = 0;
  int          wr_base;
  int          n_assert = 0;
  int          n_fail = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_a(if_a), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_a(lsb_a), .lsb_l(lsb_l), .lsb_w(lsb_w),
    .lsb_done(lsb_done), .lsb_r(lsb_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rdy) mem_din <= ram[mem_a[11:0]];
  end

  always @(posedge clk) begin
    if (mem_wr === 1'b1) begin
      wr_a_log[wr_cnt[3:0]] <= mem_a;
      wr_d_log[wr_cnt[3:0]] <= mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h104] = 8'hEF; ram[12'h105] = 8'hBE; ram[12'h106] = 8'hAD; ram[12'h107] = 8'hDE;
    ram[12'h200] = 8'h93; ram[12'h201] = 8'h00; ram[12'h202] = 8'h10; ram[12'h203] = 8'h00;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_en = 1'b0; if_a = 32'd0; lsb_en = 1'b0; lsb_wr = 1'b0;
    lsb_a = 32'd0; lsb_l = 3'd0; lsb_w = 32'd0;
    tick(); tick();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    check("rst_lsb_r", lsb_r, 32'd0);
    rst = 1'b0;
    tick();

    // LW 0x100: one address per cycle, done after e5
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_a = 32'h100; lsb_l = 3'd4;
    tick(); check("lw_a0", mem_a, 32'h100);
    check("lw_no_wr", {31'd0, mem_wr}, 32'd0);
    tick(); check("lw_a1", mem_a, 32'h101);
    tick(); check("lw_a2", mem_a, 32'h102);
    tick(); check("lw_a3", mem_a, 32'h103);
    tick(); check("lw_done_e4", {31'd0, lsb_done}, 32'd0);
    tick(); check("lw_done_e5", {31'd0, lsb_done}, 32'd1);
    check("lw_data", lsb_r, 32'h44332211);
    lsb_en = 1'b0;
    tick(); check("lw_done_pulse", {31'd0, lsb_done}, 32'd0);

    // SH 0xAABBCCDD at 0x3FFFF crossing into 0x40000
    wr_base = wr_cnt;
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_a = 32'h0003FFFF; lsb_l = 3'd2; lsb_w = 32'hAABBCCDD;
    tick(); check("sh_wr0", {31'd0, mem_wr}, 32'd1);
    check("sh_a0", mem_a, 32'h0003FFFF);
    check("sh_d0", {24'd0, mem_dout}, 32'h000000DD);
    tick(); check("sh_wr1", {31'd0, mem_wr}, 32'd1);
    check("sh_a1", mem_a, 32'h00040000);
    check("sh_d1", {24'd0, mem_dout}, 32'h000000CC);
    check("sh_done_e1", {31'd0, lsb_done}, 32'd0);
    tick(); check("sh_done_e2", {31'd0, lsb_done}, 32'd1);
    check("sh_wr_off", {31'd0, mem_wr}, 32'd0);
    lsb_en = 1'b0;
    check("sh_nwrites", wr_cnt - wr_base, 32'd2);
    check("sh_log_a0", wr_a_log[wr_base[3:0]], 32'h0003FFFF);
    check("sh_log_d1", {24'd0, wr_d_log[wr_base[3:0] + 4'd1]}, 32'h000000CC);
    tick(); check("sh_done_pulse", {31'd0, lsb_done}, 32'd0);

    // SB to IO space 0x30000 with io_buffer_full high for 3 cycles
    wr_base = wr_cnt;
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_a = 32'h00030000; lsb_l = 3'd1; lsb_w = 32'h0000005A;
    io_buffer_full = 1'b1;
    tick(); check("sb_stall1", {31'd0, mem_wr}, 32'd0);
    tick(); check("sb_stall2", {31'd0, mem_wr}, 32'd0);
    tick(); check("sb_stall3", {31'd0, mem_wr}, 32'd0);
    check("sb_done_early", {31'd0, lsb_done}, 32'd0);
    tick(); io_buffer_full = 1'b0; #1;
    check("sb_wr_release", {31'd0, mem_wr}, 32'd1);
    check("sb_no_write_yet", wr_cnt - wr_base, 32'd0);
    tick(); check("sb_done_e4", {31'd0, lsb_done}, 32'd1);
    lsb_en = 1'b0;
    check("sb_nwrites", wr_cnt - wr_base, 32'd1);
    check("sb_log_a", wr_a_log[wr_base[3:0]], 32'h00030000);
    check("sb_log_d", {24'd0, wr_d_log[wr_base[3:0]]}, 32'h0000005A);
    tick();

    // LB and IF together: LB first, IF after lsb_done falls, then rollback mid-IF
    if_en = 1'b1; if_a = 32'h200;
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_a = 32'h100; lsb_l = 3'd1;
    tick(); check("arb_lsb_first", mem_a, 32'h100);
    tick();
    tick(); check("lb_done", {31'd0, lsb_done}, 32'd1);
    check("lb_data", lsb_r, 32'h00000011);
    check("lb_if_idle", {31'd0, if_done}, 32'd0);
    lsb_en = 1'b0;
    tick(); check("if_not_yet", mem_a, 32'h100);
    tick(); check("if_accept", mem_a, 32'h200);
    tick(); check("if_a1", mem_a, 32'h201);
    rollback = 1'b1; if_en = 1'b0;
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_a = 32'h101; lsb_l = 3'd1;
    tick(); check("rb_hold_a", mem_a, 32'h201);
    check("rb_no_done", {31'd0, if_done}, 32'd0);
    rollback = 1'b0;
    tick(); check("rb_lb_accept", mem_a, 32'h101);
    check("rb_no_done2", {31'd0, if_done}, 32'd0);
    tick(); check("rb_lb_e1", {31'd0, lsb_done}, 32'd0);
    tick(); check("rb_lb_done", {31'd0, lsb_done}, 32'd1);
    check("rb_lb_data", lsb_r, 32'h00000022);
    check("rb_no_done3", {31'd0, if_done}, 32'd0);
    lsb_en = 1'b0;
    tick();

    // LW 0x104 with rdy low for 2 cycles: done delayed by exactly 2
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_a = 32'h104; lsb_l = 3'd4;
    tick(); check("rdy_a0", mem_a, 32'h104);
    tick(); check("rdy_a1", mem_a, 32'h105);
    rdy = 1'b0;
    tick(); check("rdy_hold1", mem_a, 32'h105);
    tick(); check("rdy_hold2", mem_a, 32'h105);
    rdy = 1'b1;
    tick(); check("rdy_a2", mem_a, 32'h106);
    tick(); check("rdy_a3", mem_a, 32'h107);
    tick(); check("rdy_done_early", {31'd0, lsb_done}, 32'd0);
    tick(); check("rdy_done", {31'd0, lsb_done}, 32'd1);
    check("rdy_data", lsb_r, 32'hDEADBEEF);
    lsb_en = 1'b0;
    tick();

    // Plain instruction fetch from 0x200
    if_en = 1'b1; if_a = 32'h200;
    for (int k = 0; k < 4; k++) begin
      tick(); check("if_addr", mem_a, 32'h200 + k);
    end
    tick(); check("if_done_e4", {31'd0, if_done}, 32'd0);
    tick(); check("if_done_e5", {31'd0, if_done}, 32'd1);
    check("if_data", if_data, 32'h00100093);
    if_en = 1'b0;
    tick(); check("if_done_pulse", {31'd0, if_done}, 32'd0);

    // SW at 0x300, reset after byte 1 is written
    wr_base = wr_cnt;
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_a = 32'h300; lsb_l = 3'd4; lsb_w = 32'h11223344;
    tick(); tick();
    check("sw_a1", mem_a, 32'h301);
    tick();
    rst = 1'b1; #1;
    check("rstm_mem_a", mem_a, 32'd0);
    check("rstm_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rstm_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rstm_lsb_r", lsb_r, 32'd0);
    check("rstm_if_data", if_data, 32'd0);
    check("rstm_lsb_done", {31'd0, lsb_done}, 32'd0);
    tick(); tick();
    lsb_en = 1'b0; rst = 1'b0;
    tick(); tick(); tick();
    check("rstm_nwrites", wr_cnt - wr_base, 32'd2);
    check("rstm_log_d1", {24'd0, wr_d_log[wr_base[3:0] + 4'd1]}, 32'h00000033);
    check("rstm_idle_wr", {31'd0, mem_wr}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the CPU core and the single-port 8-bit RAM/IO bus. It arbitrates between instruction fetch (IF, always 4-byte reads) and the load/store buffer (LSB, 1/2/4-byte loads and stores). Each request is serialised into little-endian byte accesses, and the controller returns a one-cycle done pulse with the assembled word. It sits directly downstream of the LSB's mem_en/mem_wr/mem_a/mem_l/mem_w ↔ mem_r/mem_done port.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global ready; 0 freezes all state
- rollback  in  1  pipeline flush; aborts an in-flight IF read
- mem_din  in  8  RAM read data (byte addressed in previous cycle)
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe (1 = write)
- io_buffer_full  in  1  IO write buffer full; blocks writes to IO space (a[17:16] == 2'b11)
- if_en  in  1  fetch request, held until if_done seen
- if_a  in  32  fetch address
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched instruction word
- lsb_en  in  1  LSB request, held until lsb_done seen
- lsb_wr  in  1  0 = load, 1 = store
- lsb_a  in  32  base byte address
- lsb_l  in  3  length in bytes: 1, 2 or 4
- lsb_w  in  32  store data, byte 0 = bits 7:0
- lsb_done  out  1  one-cycle pulse: transaction complete
- lsb_r  out  32  load data, zero-extended above lsb_l bytes (sign extension is the LSB's job)

## Operation
- States: IDLE, IF, LOAD, STORE. Registered byte index idx (0..4), base address, length, and 32-bit assembly buffer.
- IDLE accepts a request only when all of these hold: rdy=1, rollback=0, if_done=0, lsb_done=0. The done conditions guarantee a requester sees its done pulse and drops its enable before it can be re-accepted.
- Arbitration: lsb_en wins over if_en. IF is accepted only when lsb_en=0.
- On acceptance, latch address/length/data, set idx=0, and enter LOAD, STORE or IF (IF length = 4).
- Read states (IF, LOAD):
  - Drive mem_a = base+idx while idx < len.
  - The byte returned on mem_din one cycle later is stored into buffer byte idx-1.
  - When byte len-1 is captured: register the result into if_data or lsb_r, pulse the done output, return to IDLE.
- STORE:
  - Drive mem_a = base+idx, mem_dout = lsb_w byte idx, mem_wr=1.
  - idx advances only when the byte is actually written.
  - After byte len-1 is written: pulse lsb_done, return to IDLE.
- IO stall: if mem_a[17:16]==2'b11 and io_buffer_full=1, mem_wr is forced to 0 that cycle and idx holds. The stall is decided combinationally from the same-cycle io_buffer_full.
- rdy=0: state, idx and outputs hold; mem_wr is forced to 0 (no duplicate write).
- rollback:
  - In IF: return to IDLE at that edge, if_done stays 0, including when the completing byte arrives at the same edge.
  - In LOAD/STORE: no effect; the transaction completes normally (the LSB owns cancellation).
  - In IDLE: no request is accepted that cycle.
- Address arithmetic is 32-bit wrap-around. Non-aligned accesses are legal.
- When not writing, mem_a holds the last driven address and mem_dout is don't-care.

## Timing
- Reset (async) values: state IDLE, idx 0, mem_a 0, mem_dout 0, mem_wr 0, if_done 0, if_data 0, lsb_done 0, lsb_r 0.
- Edge e0 is the acceptance edge. Read byte k: mem_a valid in the cycle after e_k, captured at e_{k+2}. The done pulse is registered at e_{len+1}:
  - IF or LW: done high after e5.
  - LB: done high after e2.
- Store byte k is written at e_{k+1}; lsb_done is registered at e_len. SW: done high after e4. Each IO stall cycle adds one cycle.
- Done outputs are high for exactly one cycle (with rdy=1).
- Minimum gap between transactions: the done-high cycle. The next acceptance is at the edge after done falls, so back-to-back requests start 1 cycle after the done pulse.
- Simultaneous if_en and lsb_en in IDLE: LSB first; IF is served after lsb_done clears.

## Test plan
- Reset mid-STORE: assert rst after byte 1 → all outputs return to reset values immediately; no further writes.
- LW at 0x100, RAM bytes 11,22,33,44 → mem_a 0x100..0x103 on consecutive cycles; lsb_done one cycle after e5 with lsb_r=0x44332211.
- SH lsb_w=0xAABBCCDD at 0x3FFFF (wrap not crossing) → writes 0xDD@0x3FFFF, 0xCC@0x40000, mem_wr high exactly 2 cycles, lsb_done after e2.
- SB to 0x30000 with io_buffer_full high 3 cycles → mem_wr stays 0 for 3 cycles, single write of the byte, done 3 cycles later than unstalled.
- if_en and lsb_en (LB) together → LB done first, IF accepted the edge after lsb_done falls; rollback asserted mid-IF → no if_done, IDLE next cycle, pending LB unaffected.
- rdy low 2 cycles during LW → no mem_a advance, done delayed by exactly 2 cycles, data unchanged.
